// File: rtl/axis_frame_combiner_pkg.sv
// Shared types for the AXI-Stream frame combiner.
// Holds the sync state encoding and the status counter width.
package axis_frame_combiner_pkg;

    typedef enum logic {
        UNSYNCED = 1'b0,
        RUN      = 1'b1
    } state_e;

    localparam int STAT_W = 32;

endpackage

// File: rtl/axis_frame_combiner_if.sv
// AXI-Stream bundle for the frame combiner ports.
// The tuser wire exists only when AXIS_FRAME_COMBINER_TUSER_EN is defined.
interface axis_frame_combiner_if #(
    parameter int DW = 32
) ();

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

`ifdef AXIS_FRAME_COMBINER_TUSER_EN
    logic          tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );
`else
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );
`endif

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: one cycle latency, registered
// in_ready, and no combinational path from out_ready to in_ready.
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0][W-1:0] mem_q;
    logic [1:0][W-1:0] mem_d;
    logic              wr_q;
    logic              wr_d;
    logic              rd_q;
    logic              rd_d;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              rdy_q;
    logic              rdy_d;
    logic              push;
    logic              pop;

    assign push      = in_valid & rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rd_q];
    assign in_ready  = rdy_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = in_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        // Ready reflects the occupancy after this edge, so it can be a flop.
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

endmodule

// File: rtl/axis_frame_combiner.sv
// Merges N input packets into one output frame after syncing on a tlast.
// Define AXIS_FRAME_COMBINER_TUSER_EN to add a start-of-frame tuser bit.
module axis_frame_combiner
    import axis_frame_combiner_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH     = 32,
    parameter int CNT_WIDTH            = 16,
    parameter int DISCARD_FIRST_PACKET = 1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    axis_frame_combiner_if.slave  s_axis,
    axis_frame_combiner_if.master m_axis,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic                  resync,
    output logic                  synced_out,
    output logic [STAT_W-1:0]     frame_count,
    output logic [STAT_W-1:0]     drop_count
);

`ifdef AXIS_FRAME_COMBINER_TUSER_EN
    localparam int PW = AXIS_TDATA_WIDTH + 2;
`else
    localparam int PW = AXIS_TDATA_WIDTH + 1;
`endif

    localparam state_e RST_ST =
        (DISCARD_FIRST_PACKET != 0) ? UNSYNCED : RUN;

    function automatic logic [CNT_WIDTH-1:0] last_idx(
        input logic [CNT_WIDTH-1:0] n
    );
        return (n == '0) ? '0 : n - CNT_WIDTH'(1);
    endfunction

    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] cfg_d;
    logic                 pend_q;
    logic                 pend_d;
    logic                 open_q;
    logic                 open_d;
    logic                 init_q;
    logic                 init_d;
    logic [STAT_W-1:0]    frame_q;
    logic [STAT_W-1:0]    frame_d;
    logic [STAT_W-1:0]    drop_q;
    logic [STAT_W-1:0]    drop_d;

    logic                 s_ready;
    logic                 accept;
    logic                 at_sof;
    logic                 idle;
    logic                 go_unsync;
    logic                 run_eff;
    logic                 fwd;
    logic                 last_out;
    logic [PW-1:0]        sb_in;
    logic [PW-1:0]        sb_out;
    logic                 sb_valid;

    assign accept   = s_axis.tvalid & s_ready;
    assign at_sof   = (cnt_q == last_idx(cfg_q)) & ~open_q;
    assign idle     = (state_q == UNSYNCED) | at_sof;
    // A resync at a frame boundary takes effect now; otherwise it waits.
    assign go_unsync = (resync | pend_q) & idle;
    assign run_eff   = (state_q == RUN) & ~go_unsync;
    assign fwd       = accept & run_eff;
    assign last_out  = s_axis.tlast & (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        pend_d  = pend_q;
        open_d  = open_q;
        init_d  = 1'b0;
        frame_d = frame_q;
        drop_d  = drop_q;

        if (resync) begin
            pend_d = 1'b1;
        end
        if (init_q) begin
            cfg_d = cfg_count;
            cnt_d = last_idx(cfg_count);
        end
        if (go_unsync) begin
            state_d = UNSYNCED;
            pend_d  = 1'b0;
            open_d  = 1'b0;
        end

        if (accept && !run_eff) begin
            drop_d = drop_q + STAT_W'(1);
            if ((state_q == UNSYNCED) && !go_unsync && s_axis.tlast) begin
                state_d = RUN;
                cfg_d   = cfg_count;
                cnt_d   = last_idx(cfg_count);
                open_d  = 1'b0;
            end
        end

        if (fwd) begin
            open_d = ~s_axis.tlast;
            if (s_axis.tlast) begin
                if (cnt_q == '0) begin
                    frame_d = frame_q + STAT_W'(1);
                    cfg_d   = cfg_count;
                    cnt_d   = last_idx(cfg_count);
                    if (resync || pend_q) begin
                        state_d = UNSYNCED;
                        pend_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
            cfg_q   <= '0;
            pend_q  <= 1'b0;
            open_q  <= 1'b0;
            init_q  <= 1'b1;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            pend_q  <= pend_d;
            open_q  <= open_d;
            init_q  <= init_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

`ifdef AXIS_FRAME_COMBINER_TUSER_EN
    assign sb_in = {at_sof, last_out, s_axis.tdata};
    assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = sb_out;
`else
    assign sb_in = {last_out, s_axis.tdata};
    assign {m_axis.tlast, m_axis.tdata} = sb_out;
`endif

    axis_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk       (axis_aclk),
        .rst       (axis_areset),
        .in_data   (sb_in),
        .in_valid  (s_axis.tvalid & run_eff),
        .in_ready  (s_ready),
        .out_data  (sb_out),
        .out_valid (sb_valid),
        .out_ready (m_axis.tready)
    );

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = sb_valid;
    assign synced_out    = (state_q == RUN);
    assign frame_count   = frame_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_frame_combiner.sv
// Directed bench for axis_frame_combiner with hand-computed expectations.
module tb_axis_frame_combiner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_count;
    logic        resync;
    logic        synced;
    logic [31:0] frames;
    logic [31:0] drops;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    bit          tog_en = 1'b0;
    bit          hold_en = 1'b0;

    axis_frame_combiner_if #(.DW(32)) s_if ();
    axis_frame_combiner_if #(.DW(32)) m_if ();

    axis_frame_combiner #(
        .AXIS_TDATA_WIDTH     (32),
        .CNT_WIDTH            (16),
        .DISCARD_FIRST_PACKET (1)
    ) dut (
        .axis_aclk   (clk),
        .axis_areset (rst),
        .s_axis      (s_if.slave),
        .m_axis      (m_if.master),
        .cfg_count   (cfg_count),
        .resync      (resync),
        .synced_out  (synced),
        .frame_count (frames),
        .drop_count  (drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) m_if.tready = ~m_if.tready;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit done;
        done = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_if.tready;
            tick();
            resync = 1'b0;
        end
        s_if.tvalid = 1'b0;
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk(tag, 64'(out_q[i]), 64'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    logic        pv;
    logic        pr;
    logic        pl;
    logic [31:0] pd;

    // Output monitor; also checks that a stalled beat is held stable.
    always @(negedge clk) begin
        if (hold_en && pv && !pr)
            chk("hold", {30'b0, m_if.tvalid, m_if.tlast, m_if.tdata},
                {30'b0, 1'b1, pl, pd});
        if (m_if.tvalid && m_if.tready)
            out_q.push_back({m_if.tlast, m_if.tdata});
        pv = m_if.tvalid;
        pr = m_if.tready;
        pl = m_if.tlast;
        pd = m_if.tdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        cfg_count   = 16'd4;
        resync      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_mlast", 64'(m_if.tlast), 64'd0);
        chk("rst_mdata", 64'(m_if.tdata), 64'd0);
        chk("rst_sready", 64'(s_if.tready), 64'd0);
        chk("rst_frames", 64'(frames), 64'd0);
        chk("rst_drops", 64'(drops), 64'd0);
        chk("rst_synced", 64'(synced), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_sready0", 64'(s_if.tready), 64'd0);
        tick();
        chk("rel_sready1", 64'(s_if.tready), 64'd1);

        // 9 packets of 3 beats, N=4: first dropped, two 12-beat frames
        for (int p = 1; p <= 9; p++) begin
            for (int b = 0; b < 3; b++) begin
                d = 32'(p * 16 + b);
                send_beat(d, b == 2);
                if (p >= 2)
                    exp_q.push_back({(b == 2) && (p == 5 || p == 9), d});
            end
        end
        repeat (6) tick();
        check_out("n4_out");
        chk("n4_frames", 64'(frames), 64'd2);
        chk("n4_drops", 64'(drops), 64'd3);
        chk("n4_synced", 64'(synced), 64'd1);

        // cfg 0 via resync at a frame boundary: every beat is a frame
        cfg_count = 16'd0;
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs_idle_synced", 64'(synced), 64'd0);
        for (int k = 0; k < 6; k++) begin
            d = 32'h100 + 32'(k);
            send_beat(d, 1'b1);
            if (k > 0) exp_q.push_back({1'b1, d});
        end
        repeat (6) tick();
        check_out("n0_out");
        chk("n0_frames", 64'(frames), 64'd7);
        chk("n0_drops", 64'(drops), 64'd4);

        // cfg 4 -> 2 mid-frame: current frame keeps 4 packets
        cfg_count = 16'd4;
        for (int p = 0; p <= 6; p++) begin
            if (p == 3) cfg_count = 16'd2;
            for (int b = 0; b < 2; b++) begin
                d = 32'h200 + 32'(p * 4 + b);
                send_beat(d, b == 1);
                exp_q.push_back({(b == 1) && (p == 0 || p == 4 || p == 6), d});
            end
        end
        repeat (6) tick();
        check_out("cfgchg_out");
        chk("cfgchg_frames", 64'(frames), 64'd10);

        // resync during packet 2 of a 4-packet frame
        cfg_count = 16'd4;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 2; b++) begin
                d = 32'h300 + 32'(p * 4 + b);
                send_beat(d, b == 1);
                exp_q.push_back({(b == 1) && (p == 1), d});
            end
        end
        for (int p = 0; p < 9; p++) begin
            for (int b = 0; b < 3; b++) begin
                d = 32'h400 + 32'(p * 4 + b);
                if (p == 1 && b == 0) resync = 1'b1;
                send_beat(d, b == 2);
                if (p != 4)
                    exp_q.push_back({(b == 2) && (p == 3 || p == 8), d});
            end
            if (p == 1) chk("rs_pend_synced", 64'(synced), 64'd1);
            if (p == 3) chk("rs_end_synced", 64'(synced), 64'd0);
        end
        repeat (6) tick();
        check_out("rs_out");
        chk("rs_frames", 64'(frames), 64'd13);
        chk("rs_drops", 64'(drops), 64'd7);
        chk("rs_synced", 64'(synced), 64'd1);

        // Throttled output and gappy input: order and count preserved
        tog_en  = 1'b1;
        hold_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                d = $urandom;
                send_beat(d, b == 3);
                exp_q.push_back({(b == 3) && (p == 3), d});
            end
        end
        repeat (20) tick();
        tog_en  = 1'b0;
        hold_en = 1'b0;
        m_if.tready = 1'b1;
        repeat (4) tick();
        check_out("bp_out");
        chk("bp_frames", 64'(frames), 64'd14);

        // Reset mid-frame with two beats buffered
        m_if.tready = 1'b0;
        send_beat(32'hA1, 1'b0);
        send_beat(32'hA2, 1'b0);
        chk("pre_rst_mvalid", 64'(m_if.tvalid), 64'd1);
        chk("pre_rst_sready", 64'(s_if.tready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_mvalid", 64'(m_if.tvalid), 64'd0);
        chk("mid_rst_frames", 64'(frames), 64'd0);
        chk("mid_rst_drops", 64'(drops), 64'd0);
        chk("mid_rst_synced", 64'(synced), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        m_if.tready = 1'b1;
        repeat (4) tick();
        check_out("rst_flush");
        send_beat(32'hB1, 1'b1);
        repeat (4) tick();
        check_out("post_rst_out");
        chk("post_rst_drops", 64'(drops), 64'd1);
        chk("post_rst_frames", 64'(frames), 64'd0);
        chk("post_rst_synced", 64'(synced), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
